// File: rtl/ethernet_mac_rx_frame_ctrl.sv
// Receive store-and-forward frame controller: buffers each frame, filters on DA,
// commits or rolls back on the last byte, and replays good frames on AXI-Stream.
module ethernet_mac_rx_frame_ctrl #(
    parameter int ADDR_WIDTH     = 11,
    parameter int LEN_FIFO_DEPTH = 8,
    parameter bit STRIP_FCS      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    input  logic        s_tuser,
    input  logic        mac_address_filter,
    input  logic [47:0] mac_address,
    input  logic        accept_multicast,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [15:0] stat_good,
    output logic [15:0] stat_err,
    output logic [15:0] stat_filtered,
    output logic [15:0] stat_overflow
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int LF_AW = $clog2(LEN_FIFO_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_HDR, W_BODY, W_DROP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} rd_state_e;

    logic [7:0]    mem [1 << ADDR_WIDTH];
    logic [PW-1:0] lf_mem [LEN_FIFO_DEPTH];

    wr_state_e     wr_state_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] frame_start_q;
    logic [PW-1:0] len_q;
    logic          da_eq_q;
    logic          da_bc_q;
    logic          da_mc_q;
    logic          hit_q;

    rd_state_e     rd_state_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rem_q;
    logic [7:0]    rdata_q;
    logic [7:0]    m_tdata_q;
    logic          m_tvalid_q;
    logic          m_tlast_q;

    logic [LF_AW:0] lf_wr_q;
    logic [LF_AW:0] lf_rd_q;

    logic [15:0] stat_good_q;
    logic [15:0] stat_err_q;
    logic [15:0] stat_filtered_q;
    logic [15:0] stat_overflow_q;

    logic                  full_d;
    logic                  lf_full_d;
    logic                  lf_empty_d;
    logic                  first_d;
    logic [2:0]            hdr_idx_d;
    logic [7:0]            da_byte_d;
    logic                  eq_d;
    logic                  bc_d;
    logic                  mc_d;
    logic                  hit_d;
    logic                  wr_en_d;
    logic                  beat_ovf_d;
    logic                  ovf_d;
    logic                  err_d;
    logic                  good_d;
    logic [PW-1:0]         base_d;
    logic [PW-1:0]         len_d;
    logic [PW-1:0]         commit_len_d;
    logic [ADDR_WIDTH-1:0] rd_a1_d;
    logic [ADDR_WIDTH-1:0] rd_a2_d;

    always_comb begin
        full_d     = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        lf_full_d  = (lf_wr_q[LF_AW] != lf_rd_q[LF_AW]) &&
                     (lf_wr_q[LF_AW-1:0] == lf_rd_q[LF_AW-1:0]);
        lf_empty_d = (lf_wr_q == lf_rd_q);
        first_d    = (wr_state_q == W_IDLE);
        hdr_idx_d  = (wr_state_q == W_HDR) ? len_q[2:0] : 3'd0;

        case (hdr_idx_d)
            3'd0:    da_byte_d = mac_address[47:40];
            3'd1:    da_byte_d = mac_address[39:32];
            3'd2:    da_byte_d = mac_address[31:24];
            3'd3:    da_byte_d = mac_address[23:16];
            3'd4:    da_byte_d = mac_address[15:8];
            3'd5:    da_byte_d = mac_address[7:0];
            default: da_byte_d = '0;
        endcase

        // DA match terms accumulate byte by byte; hit is final once byte 5 is seen
        eq_d  = (first_d ? 1'b1 : da_eq_q) && (s_tdata == da_byte_d);
        bc_d  = (first_d ? 1'b1 : da_bc_q) && (s_tdata == 8'hFF);
        mc_d  = first_d ? s_tdata[0] : da_mc_q;
        hit_d = (wr_state_q == W_BODY) ? hit_q :
                (~mac_address_filter | eq_d | bc_d | (accept_multicast & mc_d));

        wr_en_d    = s_tvalid && (wr_state_q != W_DROP) && !full_d;
        beat_ovf_d = s_tvalid && (wr_state_q != W_DROP) && full_d;
        base_d     = first_d ? wr_ptr_q : frame_start_q;
        len_d      = (first_d ? '0 : len_q) + (wr_en_d ? PW'(1) : PW'(0));

        ovf_d  = (wr_state_q == W_DROP) || beat_ovf_d || lf_full_d;
        err_d  = s_tuser || (len_d < PW'(6)) || (STRIP_FCS && (len_d <= PW'(10)));
        good_d = s_tvalid && s_tlast && !ovf_d && !err_d && hit_d;
        commit_len_d = len_d - (STRIP_FCS ? PW'(4) : PW'(0));

        rd_a1_d = rd_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
        rd_a2_d = rd_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(2);
    end

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_tdata;
        end
        if (good_d) begin
            lf_mem[lf_wr_q[LF_AW-1:0]] <= commit_len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_state_q      <= W_IDLE;
            wr_ptr_q        <= '0;
            frame_start_q   <= '0;
            len_q           <= '0;
            da_eq_q         <= 1'b0;
            da_bc_q         <= 1'b0;
            da_mc_q         <= 1'b0;
            hit_q           <= 1'b0;
            lf_wr_q         <= '0;
            stat_good_q     <= '0;
            stat_err_q      <= '0;
            stat_filtered_q <= '0;
            stat_overflow_q <= '0;
        end else if (s_tvalid) begin
            len_q <= len_d;
            if (wr_state_q inside {W_IDLE, W_HDR}) begin
                da_eq_q <= eq_d;
                da_bc_q <= bc_d;
                da_mc_q <= mc_d;
            end
            if (first_d) begin
                frame_start_q <= wr_ptr_q;
            end
            if (wr_en_d) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end

            if (s_tlast) begin
                // The last byte was already written above; commit trims FCS, rollback drops all
                wr_state_q <= W_IDLE;
                if (good_d) begin
                    wr_ptr_q <= base_d + commit_len_d;
                    lf_wr_q  <= lf_wr_q + (LF_AW+1)'(1);
                    if (stat_good_q != '1) stat_good_q <= stat_good_q + 16'd1;
                end else begin
                    wr_ptr_q <= base_d;
                    if (ovf_d) begin
                        if (stat_overflow_q != '1) stat_overflow_q <= stat_overflow_q + 16'd1;
                    end else if (err_d) begin
                        if (stat_err_q != '1) stat_err_q <= stat_err_q + 16'd1;
                    end else begin
                        if (stat_filtered_q != '1) stat_filtered_q <= stat_filtered_q + 16'd1;
                    end
                end
            end else if (!wr_en_d) begin
                wr_state_q <= W_DROP;
            end else if (first_d) begin
                wr_state_q <= W_HDR;
            end else if ((wr_state_q == W_HDR) && (len_q == PW'(5))) begin
                hit_q      <= hit_d;
                wr_state_q <= W_BODY;
            end
        end
    end

    // rdata_q always holds the byte after the one in m_tdata, so accepts never bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_state_q <= R_IDLE;
            rd_ptr_q   <= '0;
            rem_q      <= '0;
            lf_rd_q    <= '0;
            rdata_q    <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (!lf_empty_d) begin
                        rem_q      <= lf_mem[lf_rd_q[LF_AW-1:0]];
                        lf_rd_q    <= lf_rd_q + (LF_AW+1)'(1);
                        rdata_q    <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
                        rd_state_q <= R_LOAD;
                    end
                end
                R_LOAD: begin
                    m_tdata_q  <= rdata_q;
                    m_tvalid_q <= 1'b1;
                    m_tlast_q  <= (rem_q == PW'(1));
                    rdata_q    <= mem[rd_a1_d];
                    rd_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (m_tready) begin
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        if (rem_q == PW'(1)) begin
                            m_tvalid_q <= 1'b0;
                            m_tlast_q  <= 1'b0;
                            rd_state_q <= R_IDLE;
                        end else begin
                            m_tdata_q <= rdata_q;
                            m_tlast_q <= (rem_q == PW'(2));
                            rem_q     <= rem_q - PW'(1);
                            rdata_q   <= mem[rd_a2_d];
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign m_tdata       = m_tdata_q;
    assign m_tvalid      = m_tvalid_q;
    assign m_tlast       = m_tlast_q;
    assign stat_good     = stat_good_q;
    assign stat_err      = stat_err_q;
    assign stat_filtered = stat_filtered_q;
    assign stat_overflow = stat_overflow_q;

endmodule

// File: tb/tb_ethernet_mac_rx_frame_ctrl.sv
// Directed bench for ethernet_mac_rx_frame_ctrl: a 2048-byte instance for the main
// scenarios and a 64-byte instance for buffer overflow, sharing the input stream.
module tb_ethernet_mac_rx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tuser;
    logic        filt;
    logic        amc;
    logic [47:0] mac;
    logic        rdy;
    logic        use_small;

    logic        vb, vs, trb, trs;
    logic [7:0]  b_tdata, sm_tdata;
    logic        b_tvalid, b_tlast, sm_tvalid, sm_tlast;
    logic [15:0] b_good, b_err, b_filt, b_ovf;
    logic [15:0] sm_good, sm_err, sm_filt, sm_ovf;
    logic [7:0]  o_tdata;
    logic        o_tvalid, o_tlast;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    assign vb       = s_tvalid & ~use_small;
    assign vs       = s_tvalid & use_small;
    assign trb      = rdy & ~use_small;
    assign trs      = rdy & use_small;
    assign o_tdata  = use_small ? sm_tdata  : b_tdata;
    assign o_tvalid = use_small ? sm_tvalid : b_tvalid;
    assign o_tlast  = use_small ? sm_tlast  : b_tlast;

    ethernet_mac_rx_frame_ctrl #(.ADDR_WIDTH(11), .LEN_FIFO_DEPTH(8), .STRIP_FCS(1'b1)) dut (
        .clk(clk), .reset(rst_n),
        .s_tdata(s_tdata), .s_tvalid(vb), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .mac_address_filter(filt), .mac_address(mac), .accept_multicast(amc),
        .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tready(trb), .m_tlast(b_tlast),
        .stat_good(b_good), .stat_err(b_err), .stat_filtered(b_filt), .stat_overflow(b_ovf)
    );

    ethernet_mac_rx_frame_ctrl #(.ADDR_WIDTH(6), .LEN_FIFO_DEPTH(8), .STRIP_FCS(1'b1)) dut_small (
        .clk(clk), .reset(rst_n),
        .s_tdata(s_tdata), .s_tvalid(vs), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .mac_address_filter(filt), .mac_address(mac), .accept_multicast(amc),
        .m_tdata(sm_tdata), .m_tvalid(sm_tvalid), .m_tready(trs), .m_tlast(sm_tlast),
        .stat_good(sm_good), .stat_err(sm_err), .stat_filtered(sm_filt), .stat_overflow(sm_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [47:0] da, input int i, input int seed);
        logic [47:0] t;
        if (i < 6) begin
            t = da << (8 * i);
            return t[47:40];
        end
        return 8'((i * 7 + seed * 13) & 255);
    endfunction

    task automatic send(input logic [47:0] da, input int len, input int seed, input bit err);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = fbyte(da, i, seed);
            s_tlast  = (i == len - 1);
            s_tuser  = err && (i == len - 1);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic expect_frame(input logic [47:0] da, input int len, input int seed);
        for (int i = 0; i < len - 4; i++) begin
            exp_q.push_back({(i == len - 5), fbyte(da, i, seed)});
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after send(): the commit edge has just passed
    task automatic check_latency(input string tag);
        check({tag, "_lat1"}, 32'(o_tvalid), 0);
        @(negedge clk);
        check({tag, "_lat2"}, 32'(o_tvalid), 0);
        @(negedge clk);
        check({tag, "_lat3"}, 32'(o_tvalid), 1);
    endtask

    task automatic collect(input int n, input bit rnd, output int lasts);
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] pd = '0;
        logic pl = 1'b0;
        logic [8:0] e;
        lasts = 0;
        while (got < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("hold_valid", 32'(o_tvalid), 1);
                check("hold_data", 32'(o_tdata), 32'(pd));
                check("hold_last", 32'(o_tlast), 32'(pl));
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_tvalid && rdy) begin
                e = exp_q.pop_front();
                check("data", 32'(o_tdata), 32'(e[7:0]));
                check("last", 32'(o_tlast), 32'(e[8]));
                lasts += int'(o_tlast);
                got++;
                stalled = 1'b0;
            end else begin
                stalled = o_tvalid;
                pd = o_tdata;
                pl = o_tlast;
            end
        end
        @(posedge clk);
        #1 rdy = 1'b0;
        check("collect_count", got, n);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0] da2, bc, mc;
        int l;
        da2 = 48'h02_00_00_00_00_01;
        bc  = 48'hFF_FF_FF_FF_FF_FF;
        mc  = 48'h01_00_5E_00_00_01;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = '0;
        mac = 48'h0A_1B_2C_3D_4E_5F; filt = 1'b1; amc = 1'b0;
        rdy = 1'b0; use_small = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 32'(o_tvalid), 0);
        check("rst_tlast", 32'(o_tlast), 0);
        check("rst_tdata", 32'(o_tdata), 0);
        check("rst_good", 32'(b_good), 0);
        check("rst_err", 32'(b_err), 0);
        check("rst_filt", 32'(b_filt), 0);
        check("rst_ovf", 32'(b_ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 64-byte good frame: 60 bytes out after FCS strip
        expect_frame(mac, 64, 1);
        send(mac, 64, 1, 1'b0);
        check("good_cnt", 32'(b_good), 1);
        check_latency("good");
        collect(60, 1'b0, l);
        check("good_lasts", l, 1);
        cycles(3);
        check("good_idle", 32'(o_tvalid), 0);

        // Errored frame rolls back; next frame intact
        send(mac, 64, 2, 1'b1);
        check("err_cnt", 32'(b_err), 1);
        check("err_good_cnt", 32'(b_good), 1);
        cycles(4);
        check("err_no_out", 32'(o_tvalid), 0);
        expect_frame(mac, 30, 3);
        send(mac, 30, 3, 1'b0);
        check("after_err_good", 32'(b_good), 2);
        check_latency("after_err");
        collect(26, 1'b0, l);

        // Length boundaries: 5 and 10 bytes are errors, 11 is the shortest good
        send(mac, 5, 4, 1'b0);
        send(mac, 10, 4, 1'b0);
        check("short_err_cnt", 32'(b_err), 3);
        expect_frame(mac, 11, 5);
        send(mac, 11, 5, 1'b0);
        check("min_good_cnt", 32'(b_good), 3);
        check_latency("min");
        collect(7, 1'b0, l);
        check("min_lasts", l, 1);

        // DA filtering
        send(da2, 20, 6, 1'b0);
        check("filt_cnt", 32'(b_filt), 1);
        send(mc, 20, 6, 1'b0);
        check("mc_rej_cnt", 32'(b_filt), 2);
        cycles(4);
        check("filt_no_out", 32'(o_tvalid), 0);
        expect_frame(bc, 20, 7);
        send(bc, 20, 7, 1'b0);
        check("bcast_good", 32'(b_good), 4);
        collect(16, 1'b0, l);
        filt = 1'b0;
        expect_frame(da2, 20, 8);
        send(da2, 20, 8, 1'b0);
        check("nofilt_good", 32'(b_good), 5);
        collect(16, 1'b0, l);
        filt = 1'b1;
        amc = 1'b1;
        expect_frame(mc, 20, 9);
        send(mc, 20, 9, 1'b0);
        check("mc_acc_good", 32'(b_good), 6);
        collect(16, 1'b0, l);
        amc = 1'b0;
        check("filt_final", 32'(b_filt), 2);

        // Back-pressure across three back-to-back 100-byte frames
        expect_frame(mac, 100, 10);
        expect_frame(mac, 100, 11);
        expect_frame(mac, 100, 12);
        fork
            begin
                send(mac, 100, 10, 1'b0);
                send(mac, 100, 11, 1'b0);
                send(mac, 100, 12, 1'b0);
            end
            collect(288, 1'b1, l);
        join
        check("bp_lasts", l, 3);
        check("bp_good", 32'(b_good), 9);
        check("bp_queue_empty", exp_q.size(), 0);

        // Overflow on the 64-byte instance with the output stalled
        @(negedge clk);
        use_small = 1'b1;
        expect_frame(mac, 40, 20);
        send(mac, 40, 20, 1'b0);
        send(mac, 40, 21, 1'b0);
        check("ovf_cnt", 32'(sm_ovf), 1);
        check("ovf_good", 32'(sm_good), 1);
        check("ovf_err", 32'(sm_err), 0);
        collect(36, 1'b0, l);
        check("ovf_lasts", l, 1);
        rdy = 1'b1;
        cycles(6);
        check("ovf_no_extra", 32'(o_tvalid), 0);
        rdy = 1'b0;
        use_small = 1'b0;
        @(negedge clk);

        // Reset while a frame is being output and another is arriving
        send(mac, 40, 30, 1'b0);
        check("pre_rst_good", 32'(b_good), 10);
        cycles(2);
        rdy = 1'b1;
        cycles(5);
        rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = fbyte(mac, i, 32);
            s_tlast  = 1'b0;
        end
        @(negedge clk);
        check("pre_rst_valid", 32'(o_tvalid), 1);
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = '0;
        @(negedge clk);
        check("rst2_tvalid", 32'(o_tvalid), 0);
        check("rst2_tlast", 32'(o_tlast), 0);
        check("rst2_good", 32'(b_good), 0);
        check("rst2_err", 32'(b_err), 0);
        check("rst2_filt", 32'(b_filt), 0);
        check("rst2_ovf", 32'(b_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        expect_frame(mac, 30, 33);
        send(mac, 30, 33, 1'b0);
        check("post_rst_good", 32'(b_good), 1);
        check_latency("post_rst");
        collect(26, 1'b0, l);
        check("post_rst_lasts", l, 1);
        cycles(4);
        check("post_rst_idle", 32'(o_tvalid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
